// File: rtl/sm_loader_pkg.sv
// -----------------------------------------------------------------------------
// sm_loader_pkg
// Shared definitions for the switch-driven RAM loader:
//   - state_t              : loader FSM state encoding (ST_HI, ST_LO, ST_WRITE)
//   - DEBOUNCE_CYCLES_DEF  : default debounce length (10 ms at 50 MHz)
//   - db_cnt_width()       : width of a debounce counter for a given length
// -----------------------------------------------------------------------------
package sm_loader_pkg;

    typedef enum logic [1:0] {
        ST_HI    = 2'd0,
        ST_LO    = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    // Counter must be able to hold values 0..cycles.
    function automatic int db_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int DB_CNT_W_DEF = db_cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/sm_debounce.sv
// -----------------------------------------------------------------------------
// sm_debounce
// Conditions one raw push key: 2-flop synchronizer, then a debouncer whose
// level only follows the synchronized input after it has differed for
// DEBOUNCE_CYCLES consecutive cycles (any bounce restarts the count), then a
// one-cycle press pulse on each 0->1 change of the debounced level.
// Press latency from a clean edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
// Ports:
//   clkIn  in   system clock
//   rst_n  in   asynchronous active-low reset
//   in     in   raw key, asynchronous, bouncy
//   level  out  debounced key level
//   pulse  out  one-cycle press pulse
// -----------------------------------------------------------------------------
module sm_debounce
    import sm_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clkIn,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic pulse
);

    localparam int               CNT_W    = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;

    // Debounce counter: advance while input disagrees with level, flip on the last count.
    always_comb begin
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                w_level_nxt = r_sync2;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= in;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nxt;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: rtl/sm_switch_ram_loader.sv
// -----------------------------------------------------------------------------
// sm_switch_ram_loader
// Operator enters a byte as two switch nibbles (high then low), confirming each
// with keyEnter; the block then issues one RAM write over a valid/ack handshake
// and auto-increments the write address. keyClear returns the address to 0
// (deferred to the end of an in-flight write).
// Ports:
//   clkIn     in   50 MHz system clock
//   rst_n     in   asynchronous active-low reset
//   swData    in   nibble from switches, sampled on an accepted key press
//   keyEnter  in   raw nibble-confirm key
//   keyClear  in   raw address-clear key
//   ramWe     out  write request, held until acknowledged
//   ramWAddr  out  write address, stable while ramWe=1
//   ramWData  out  write data {hi,lo}, stable while ramWe=1
//   ramWAck   in   write accepted when ramWe & ramWAck
//   curAddr   out  next address to be written
//   loPhase   out  high nibble latched, waiting for low nibble
//   busy      out  write in progress
// -----------------------------------------------------------------------------
module sm_switch_ram_loader
    import sm_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                  clkIn,
    input  logic                  rst_n,
    input  logic [3:0]            swData,
    input  logic                  keyEnter,
    input  logic                  keyClear,
    output logic                  ramWe,
    output logic [ADDR_WIDTH-1:0] ramWAddr,
    output logic [7:0]            ramWData,
    input  logic                  ramWAck,
    output logic [ADDR_WIDTH-1:0] curAddr,
    output logic                  loPhase,
    output logic                  busy
);

    logic w_enter_pulse;
    logic w_clear_pulse;

    state_t                r_state;
    logic [3:0]            r_hi;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wdata;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic                  r_lo_phase;
    logic                  r_busy;
    logic                  r_clr_pend;

    state_t                w_state_nxt;
    logic [3:0]            w_hi_nxt;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] w_waddr_nxt;
    logic [7:0]            w_wdata_nxt;
    logic [ADDR_WIDTH-1:0] w_cur_nxt;
    logic                  w_lo_nxt;
    logic                  w_busy_nxt;
    logic                  w_clr_pend_nxt;

    sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clkIn (clkIn),
        .rst_n (rst_n),
        .in    (keyEnter),
        .level (),
        .pulse (w_enter_pulse)
    );

    sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clkIn (clkIn),
        .rst_n (rst_n),
        .in    (keyClear),
        .level (),
        .pulse (w_clear_pulse)
    );

    // Next-state and next-output logic; clear has priority over enter in HI/LO.
    always_comb begin
        w_state_nxt    = r_state;
        w_hi_nxt       = r_hi;
        w_we_nxt       = r_we;
        w_waddr_nxt    = r_waddr;
        w_wdata_nxt    = r_wdata;
        w_cur_nxt      = r_cur;
        w_clr_pend_nxt = r_clr_pend;
        case (r_state)
            ST_HI: begin
                if (w_clear_pulse) begin
                    w_cur_nxt   = '0;
                    w_state_nxt = ST_HI;
                end else if (w_enter_pulse) begin
                    w_hi_nxt    = swData;
                    w_state_nxt = ST_LO;
                end else begin
                    w_state_nxt = ST_HI;
                end
            end
            ST_LO: begin
                if (w_clear_pulse) begin
                    w_cur_nxt   = '0;
                    w_state_nxt = ST_HI;
                end else if (w_enter_pulse) begin
                    w_wdata_nxt = {r_hi, swData};
                    w_waddr_nxt = r_cur;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_LO;
                end
            end
            ST_WRITE: begin
                // Enter is ignored here; a clear only takes effect once the write lands.
                if (w_clear_pulse) begin
                    w_clr_pend_nxt = 1'b1;
                end else begin
                    w_clr_pend_nxt = r_clr_pend;
                end
                if (r_we && ramWAck) begin
                    w_we_nxt       = 1'b0;
                    w_clr_pend_nxt = 1'b0;
                    w_state_nxt    = ST_HI;
                    if (r_clr_pend || w_clear_pulse) begin
                        w_cur_nxt = '0;
                    end else begin
                        w_cur_nxt = r_cur + ADDR_WIDTH'(1);
                    end
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default: begin
                w_state_nxt    = ST_HI;
                w_we_nxt       = 1'b0;
                w_clr_pend_nxt = 1'b0;
            end
        endcase
        w_lo_nxt   = (w_state_nxt == ST_LO);
        w_busy_nxt = (w_state_nxt == ST_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HI;
            r_hi       <= 4'd0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= 8'd0;
            r_cur      <= '0;
            r_lo_phase <= 1'b0;
            r_busy     <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hi       <= w_hi_nxt;
            r_we       <= w_we_nxt;
            r_waddr    <= w_waddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cur      <= w_cur_nxt;
            r_lo_phase <= w_lo_nxt;
            r_busy     <= w_busy_nxt;
            r_clr_pend <= w_clr_pend_nxt;
        end
    end

    assign ramWe    = r_we;
    assign ramWAddr = r_waddr;
    assign ramWData = r_wdata;
    assign curAddr  = r_cur;
    assign loPhase  = r_lo_phase;
    assign busy     = r_busy;

endmodule

// File: tb/tb_sm_switch_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_sm_switch_ram_loader
// Directed bench for the switch RAM loader with DEBOUNCE_CYCLES=4: a table of
// byte entries (nibbles, expected address/data/next address) plus hand-written
// sequences for bounce, back-pressure, clear and reset corner cases.
// -----------------------------------------------------------------------------
module tb_sm_switch_ram_loader;

    logic       clkIn = 1'b0;
    logic       rst_n;
    logic [3:0] swData;
    logic       keyEnter;
    logic       keyClear;
    logic       ramWe;
    logic [3:0] ramWAddr;
    logic [7:0] ramWData;
    logic       ramWAck;
    logic [3:0] curAddr;
    logic       loPhase;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         we_run      = 0;
    int         last_we_len = 0;
    int         lo_rises    = 0;
    logic       lo_prev     = 1'b0;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic [3:0] exp_cur;
    } vec_t;

    vec_t vecs[17];

    sm_switch_ram_loader #(.DEBOUNCE_CYCLES(4), .ADDR_WIDTH(4)) dut (
        .clkIn    (clkIn),
        .rst_n    (rst_n),
        .swData   (swData),
        .keyEnter (keyEnter),
        .keyClear (keyClear),
        .ramWe    (ramWe),
        .ramWAddr (ramWAddr),
        .ramWData (ramWData),
        .ramWAck  (ramWAck),
        .curAddr  (curAddr),
        .loPhase  (loPhase),
        .busy     (busy)
    );

    always #5 clkIn = ~clkIn;

    // Observe accepted writes, write-request length and low-phase entries mid-cycle.
    always @(negedge clkIn) begin
        if (ramWe && ramWAck) begin
            wr_addr_q.push_back(ramWAddr);
            wr_data_q.push_back(ramWData);
        end
        if (ramWe) begin
            we_run = we_run + 1;
        end else begin
            if (we_run != 0) last_we_len = we_run;
            we_run = 0;
        end
        if (loPhase && !lo_prev) lo_rises = lo_rises + 1;
        lo_prev = loPhase;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic e, input logic c);
        keyEnter = e;
        keyClear = c;
        repeat (10) tick();
        keyEnter = 1'b0;
        keyClear = 1'b0;
        repeat (10) tick();
    endtask

    task automatic expect_write(input string nm, input logic [3:0] a, input logic [7:0] d);
        check({nm, "_nwr"}, wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            check({nm, "_addr"}, {28'd0, wr_addr_q[0]}, {28'd0, a});
            check({nm, "_data"}, {24'd0, wr_data_q[0]}, {24'd0, d});
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic enter_byte(input logic [3:0] hi, input logic [3:0] lo);
        swData = hi;
        press(1'b1, 1'b0);
        swData = lo;
        press(1'b1, 1'b0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'h0, 4'hF, 4'd0,  8'h0F, 4'd1};
        vecs[1]  = '{4'h1, 4'hE, 4'd1,  8'h1E, 4'd2};
        vecs[2]  = '{4'h2, 4'hD, 4'd2,  8'h2D, 4'd3};
        vecs[3]  = '{4'h3, 4'hC, 4'd3,  8'h3C, 4'd4};
        vecs[4]  = '{4'h4, 4'hB, 4'd4,  8'h4B, 4'd5};
        vecs[5]  = '{4'h5, 4'hA, 4'd5,  8'h5A, 4'd6};
        vecs[6]  = '{4'h6, 4'h9, 4'd6,  8'h69, 4'd7};
        vecs[7]  = '{4'h7, 4'h8, 4'd7,  8'h78, 4'd8};
        vecs[8]  = '{4'h8, 4'h7, 4'd8,  8'h87, 4'd9};
        vecs[9]  = '{4'h9, 4'h6, 4'd9,  8'h96, 4'd10};
        vecs[10] = '{4'hA, 4'h5, 4'd10, 8'hA5, 4'd11};
        vecs[11] = '{4'hB, 4'h4, 4'd11, 8'hB4, 4'd12};
        vecs[12] = '{4'hC, 4'h3, 4'd12, 8'hC3, 4'd13};
        vecs[13] = '{4'hD, 4'h2, 4'd13, 8'hD2, 4'd14};
        vecs[14] = '{4'hE, 4'h1, 4'd14, 8'hE1, 4'd15};
        vecs[15] = '{4'hF, 4'h0, 4'd15, 8'hF0, 4'd0};
        vecs[16] = '{4'h5, 4'h5, 4'd0,  8'h55, 4'd1};

        // Reset state
        rst_n = 1'b0; swData = 4'h0; keyEnter = 1'b0; keyClear = 1'b0; ramWAck = 1'b1;
        repeat (3) tick();
        check("rst_outputs", {17'd0, ramWe, ramWAddr, ramWData, curAddr, loPhase, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic entry A,5
        swData = 4'hA;
        press(1'b1, 1'b0);
        check("t1_lophase_hi", {31'd0, loPhase}, 32'd1);
        swData = 4'h5;
        press(1'b1, 1'b0);
        expect_write("t1", 4'd0, 8'hA5);
        check("t1_we_len", last_we_len, 1);
        check("t1_cur", {28'd0, curAddr}, 32'd1);
        check("t1_lophase", {31'd0, loPhase}, 32'd0);

        // 2: bouncing enter key, then a clean hold
        lo_rises = 0;
        swData = 4'h7;
        for (int i = 0; i < 10; i++) begin
            keyEnter = 1'b1; tick(); tick();
            keyEnter = 1'b0; tick(); tick();
        end
        check("t2_no_press_bounce", {31'd0, loPhase}, 32'd0);
        keyEnter = 1'b1;
        n = 0;
        while (!loPhase && n < 30) begin
            tick();
            n = n + 1;
        end
        check("t2_latency", n, 8);
        keyEnter = 1'b0;
        repeat (10) tick();
        check("t2_one_press", lo_rises, 1);
        swData = 4'h9;
        press(1'b1, 1'b0);
        expect_write("t2", 4'd1, 8'h79);
        check("t2_cur", {28'd0, curAddr}, 32'd2);

        // 5: clear discards a latched high nibble
        swData = 4'h3;
        press(1'b1, 1'b0);
        check("t5_lophase_set", {31'd0, loPhase}, 32'd1);
        press(1'b0, 1'b1);
        check("t5_lophase_clr", {31'd0, loPhase}, 32'd0);
        check("t5_cur_clr", {28'd0, curAddr}, 32'd0);
        check("t5_nowrite", wr_addr_q.size(), 0);
        enter_byte(4'hC, 4'h4);
        expect_write("t5", 4'd0, 8'hC4);

        // 3: table-driven sequence covering all addresses and wrap-around
        press(1'b0, 1'b1);
        check("t3_cur_start", {28'd0, curAddr}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            enter_byte(vecs[i].hi, vecs[i].lo);
            expect_write($sformatf("t3_v%0d", i), vecs[i].exp_addr, vecs[i].exp_data);
            check($sformatf("t3_v%0d_cur", i), {28'd0, curAddr}, {28'd0, vecs[i].exp_cur});
        end

        // 4: back-pressure with enter and clear pressed during the write
        ramWAck = 1'b0;
        enter_byte(4'h6, 4'hB);
        check("t4_hold_start", {16'd0, ramWe, busy, 2'd0, ramWAddr, ramWData}, {16'd0, 1'b1, 1'b1, 2'd0, 4'd1, 8'h6B});
        keyEnter = 1'b1;
        keyClear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                keyEnter = 1'b0;
                keyClear = 1'b0;
            end
            tick();
            check($sformatf("t4_hold_%0d", i), {16'd0, ramWe, busy, 2'd0, ramWAddr, ramWData},
                  {16'd0, 1'b1, 1'b1, 2'd0, 4'd1, 8'h6B});
        end
        check("t4_nowrite_yet", wr_addr_q.size(), 0);
        ramWAck = 1'b1;
        tick();
        check("t4_after_ack", {26'd0, ramWe, busy, loPhase, curAddr[2:0]}, 32'd0);
        check("t4_cur", {28'd0, curAddr}, 32'd0);
        expect_write("t4", 4'd1, 8'h6B);

        // 6: reset during an unacknowledged write
        enter_byte(4'h2, 4'h7);
        expect_write("t6_pre", 4'd0, 8'h27);
        ramWAck = 1'b0;
        enter_byte(4'h8, 4'hE);
        check("t6_we_before", {27'd0, ramWe, ramWAddr}, {27'd0, 1'b1, 4'd1});
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {17'd0, ramWe, ramWAddr, ramWData, curAddr, loPhase, busy}, 32'd0);
        check("t6_nowrite", wr_addr_q.size(), 0);
        tick(); tick();
        rst_n = 1'b1;
        ramWAck = 1'b1;
        tick();
        enter_byte(4'hF, 4'h0);
        expect_write("t6_post", 4'd0, 8'hF0);
        check("t6_cur", {28'd0, curAddr}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sm_switch_ram_loader.md
Name: sm_switch_ram_loader

Overview:
- Board-side writer into the sm_top data RAM; the counterpart of the switch-addressed RAM read-out path that drives the 7-segment displays.
- Operator enters bytes as two 4-bit nibbles from slide switches, confirming each nibble with a push key.
- After the second nibble the block issues one RAM write over a valid/ack handshake, then auto-increments the write address.
- Sits in the board top between the raw switch/key pins and the RAM write port; the existing display path shows the result.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-level cycles required before a key change is accepted (10 ms at 50 MHz).
- ADDR_WIDTH, 4, RAM word address width.

Ports:
- clkIn  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- swData  in  4  nibble value from switches; asynchronous, sampled only on an accepted key press.
- keyEnter  in  1  raw nibble-confirm key, active-high, asynchronous, bouncy.
- keyClear  in  1  raw address-clear key, active-high, asynchronous, bouncy.
- ramWe  out  1  write request; held until acknowledged.
- ramWAddr  out  ADDR_WIDTH  write address, stable while ramWe=1.
- ramWData  out  8  write data {hi,lo}, stable while ramWe=1.
- ramWAck  in  1  RAM accepts the write in any cycle where ramWe & ramWAck; may be tied to 1.
- curAddr  out  ADDR_WIDTH  next address to be written, for the LEDs.
- loPhase  out  1  1 = high nibble latched, waiting for low nibble.
- busy  out  1  1 while in WRITE.

Behaviour:
- Reset (async, any state):
  - state=HI; ramWe=0; ramWAddr=0; ramWData=0; curAddr=0; loPhase=0; busy=0; clrPending=0.
  - Debounce counters cleared; debounced key levels = 0.
- Key conditioning:
  - Each key passes a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any bounce.
  - A one-cycle press pulse fires on each 0->1 transition of the debounced level.
  - Press latency from a clean input edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: HI, LO, WRITE.
  - HI: on enterPulse, hiReg <= swData, go to LO, loPhase=1.
  - LO: on enterPulse, ramWData <= {hiReg, swData}, ramWAddr <= curAddr, ramWe <= 1, go to WRITE.
    - ramWe rises the cycle after the pulse.
  - WRITE: busy=1; ramWe and data/address held.
    - In a cycle with ramWe & ramWAck: ramWe <= 0, curAddr <= curAddr+1 (mod 2^ADDR_WIDTH), go to HI.
    - With ramWAck tied high, ramWe is high for exactly one cycle.
- Clear:
  - clearPulse in HI or LO: curAddr <= 0, state=HI, loPhase=0; any latched high nibble is discarded.
  - clearPulse in WRITE: sets clrPending. On ack, curAddr <= 0 instead of +1 and clrPending <= 0. The in-flight write always completes.
- Simultaneous events:
  - clearPulse and enterPulse in the same cycle in HI/LO: clear wins, enter is dropped.
  - enterPulse in WRITE: dropped, not queued.
- Wrap-around: curAddr at 2^ADDR_WIDTH-1 wraps to 0 after the write; there is no full flag.
- Reset asserted mid-write: ramWe drops asynchronously; no write is reported; curAddr=0.
- No timeout: WRITE waits indefinitely for ramWAck.

Decomposition:
- Shared package sm_loader_pkg:
  - state encoding constants ST_HI, ST_LO, ST_WRITE.
  - default DEBOUNCE_CYCLES.
  - counter width derived as clog2(DEBOUNCE_CYCLES+1).
- Sub-module sm_debounce:
  - ports clkIn, rst_n, in, level, pulse; parameter DEBOUNCE_CYCLES.
  - instantiated twice, once per key.

Test Plan (DEBOUNCE_CYCLES=4, ramWAck tied 1 unless stated):
1. Reset, swData=A, press keyEnter, set swData=5, press keyEnter -> one-cycle ramWe with ramWAddr=0, ramWData=0xA5; then curAddr=1, loPhase=0.
2. keyEnter toggling every 2 cycles for 20 cycles, then held stable -> exactly one press pulse, only after 4 stable cycles; hiReg latched once.
3. 16 complete byte entries -> addresses 0..15 written in order; curAddr wraps to 0; the 17th write goes to address 0.
4. ramWAck held 0 for 10 cycles after ramWe rises; keyEnter and keyClear pressed meanwhile -> ramWe, address and data held stable, busy=1, enter dropped. On ack: curAddr=0, state HI.
5. Enter high nibble 3, then press keyClear -> loPhase=0, curAddr=0, no write. Next two entries C,4 write 0xC4 to address 0.
6. rst_n pulsed low while ramWe=1 with ramWAck=0 -> ramWe=0 in the same cycle; all outputs at their reset values; the next entry writes to address 0.
